// File: rtl/sp_ram_banked.sv
// rtl/sp_ram_banked.sv - banked single-port RAM with per-bank retention sleep; SP_RAM_BANKED_OUTREG_EN adds an output register stage
`default_nettype none

module sp_ram #(
    parameter int SIZE = 8192,
    parameter int DW   = 32,
    parameter int AW   = $clog2(SIZE)
) (
    input  logic            clk,
    input  logic            rstn_i,
    input  logic            en_i,
    input  logic            we_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [DW-1:0]   wdata_i,
    output logic [DW-1:0]   rdata_o
);
    localparam int WORDS = SIZE / (DW / 8);

    logic [DW-1:0] mem [WORDS];
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^addr_i[1:0];

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (be_i[b]) mem[addr_i[AW-1:2]][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Read data holds its last value until the next read of this bank
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rdata_o <= '0;
        end else if (en_i && !we_i) begin
            rdata_o <= mem[addr_i[AW-1:2]];
        end
    end
endmodule

module sp_ram_banked #(
    parameter int RAM_SIZE    = 32768,
    parameter int NUM_BANKS   = 4,
    parameter int INTERLEAVE  = 0,
    parameter int DATA_WIDTH  = 32,
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int ADDR_WIDTH  = $clog2(RAM_SIZE)
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [NUM_BANKS-1:0]    bank_sleep_o
);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int WIDX_W    = ADDR_WIDTH - 2;
    localparam int ROW_W     = WIDX_W - BANK_BITS;
    localparam int BANK_SIZE = RAM_SIZE / NUM_BANKS;
    localparam int IDLE_W    = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
    localparam int IDLE_W1   = IDLE_W + 1;
    localparam int WAKE_W    = $clog2(WAKE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_WAKE   = 2'd2
    } bank_st_e;

    logic [WIDX_W-1:0]     widx;
    logic [BANK_W-1:0]     bank;
    logic [ROW_W-1:0]      row;
    logic [NUM_BANKS-1:0]  bank_active;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

    assign widx = addr_i[ADDR_WIDTH-1:2];

    generate
        if (NUM_BANKS == 1) begin : g_map_single
            assign bank = '0;
            assign row  = widx;
        end else if (INTERLEAVE != 0) begin : g_map_ilv
            assign bank = widx[BANK_BITS-1:0];
            assign row  = widx[WIDX_W-1:BANK_BITS];
        end else begin : g_map_contig
            assign bank = widx[WIDX_W-1 -: BANK_BITS];
            assign row  = widx[ROW_W-1:0];
        end
    endgenerate

    // A sleeping or waking bank never grants, so bank enables need no extra gating
    assign gnt_o = req_i & bank_active[bank];

    generate
        for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
            bank_st_e          state;
            logic [IDLE_W-1:0] idle_cnt;
            logic [IDLE_W1-1:0] idle_nxt;
            logic [WAKE_W-1:0] wake_cnt;
            logic              hit;
            logic              want;

            assign want     = req_i & (bank == BANK_W'(i));
            assign hit      = gnt_o & (bank == BANK_W'(i));
            assign idle_nxt = {1'b0, idle_cnt} + 1'b1;

            assign bank_active[i]  = (state == ST_ACTIVE);
            assign bank_sleep_o[i] = (state == ST_SLEEP);

            always_ff @(posedge clk or negedge rstn_i) begin
                if (!rstn_i) begin
                    state    <= ST_ACTIVE;
                    idle_cnt <= '0;
                    wake_cnt <= '0;
                end else begin
                    case (state)
                        ST_ACTIVE: begin
                            if (hit) begin
                                idle_cnt <= '0;
                            end else if (IDLE_CYCLES > 0) begin
                                if (idle_nxt >= IDLE_W1'(IDLE_CYCLES)) state <= ST_SLEEP;
                                if (idle_cnt != IDLE_W'(IDLE_CYCLES)) idle_cnt <= idle_cnt + 1'b1;
                            end
                        end
                        ST_SLEEP: begin
                            if (want) begin
                                state    <= ST_WAKE;
                                wake_cnt <= WAKE_W'(WAKE_CYCLES);
                            end
                        end
                        ST_WAKE: begin
                            // WAKE lasts exactly WAKE_CYCLES cycles
                            if (wake_cnt <= WAKE_W'(1)) begin
                                state    <= ST_ACTIVE;
                                idle_cnt <= '0;
                                wake_cnt <= '0;
                            end else begin
                                wake_cnt <= wake_cnt - 1'b1;
                            end
                        end
                        default: state <= ST_ACTIVE;
                    endcase
                end
            end

            sp_ram #(
                .SIZE (BANK_SIZE),
                .DW   (DATA_WIDTH)
            ) u_ram (
                .clk     (clk),
                .rstn_i  (rstn_i),
                .en_i    (hit),
                .we_i    (we_i),
                .addr_i  ({row, addr_i[1:0]}),
                .be_i    (be_i),
                .wdata_i (wdata_i),
                .rdata_o (bank_rdata[i])
            );
        end
    endgenerate

    logic                  rvalid_q;
    logic                  rd_q;
    logic [BANK_W-1:0]     bank_q;
    logic [DATA_WIDTH-1:0] rdata_c;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rvalid_q <= 1'b0;
            rd_q     <= 1'b0;
            bank_q   <= '0;
        end else begin
            rvalid_q <= gnt_o;
            rd_q     <= gnt_o & ~we_i;
            bank_q   <= bank;
        end
    end

    assign rdata_c = (rvalid_q && rd_q) ? bank_rdata[bank_q] : '0;

`ifdef SP_RAM_BANKED_OUTREG_EN
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= rvalid_q;
            rdata_o  <= rdata_c;
        end
    end
`else
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_c;
`endif
endmodule

`default_nettype wire

// File: tb/tb_sp_ram_banked.sv
// tb/tb_sp_ram_banked.sv - directed self-checking bench: contiguous, interleaved and sleeping instances of sp_ram_banked
`timescale 1ns/1ps

module tb_sp_ram_banked;
`ifdef SP_RAM_BANKED_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic [2:0]  req = '0;
    logic [2:0]  gnt;
    logic [14:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  rvalid;
    logic [31:0] rdata [3];
    logic [3:0]  slp [3];

    always #5 clk = ~clk;

    // d0: contiguous, no sleep; d1: interleaved, no sleep; d2: contiguous with sleep
    sp_ram_banked #(.INTERLEAVE(0), .IDLE_CYCLES(0)) u_dut0 (
        .clk(clk), .rstn_i(rstn_i), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
        .bank_sleep_o(slp[0]));
    sp_ram_banked #(.INTERLEAVE(1), .IDLE_CYCLES(0)) u_dut1 (
        .clk(clk), .rstn_i(rstn_i), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
        .bank_sleep_o(slp[1]));
    sp_ram_banked #(.INTERLEAVE(0), .IDLE_CYCLES(8), .WAKE_CYCLES(2)) u_dut2 (
        .clk(clk), .rstn_i(rstn_i), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]),
        .bank_sleep_o(slp[2]));

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    int          cyc = 0;
    int          g_n [3];
    int          r_n [3];
    int          g_cyc [3][64];
    int          r_cyc [3][64];
    logic [31:0] r_dat [3][64];

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 3; d++) begin
            if (!rstn_i) begin
                g_n[d] = 0;
                r_n[d] = 0;
            end else begin
                if (gnt[d] && g_n[d] < 64) begin
                    g_cyc[d][g_n[d]] = cyc;
                    g_n[d]++;
                end
                if (rvalid[d] && r_n[d] < 64) begin
                    r_cyc[d][r_n[d]] = cyc;
                    r_dat[d][r_n[d]] = rdata[d];
                    r_n[d]++;
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that took the grant
    task automatic issue(input int d, input logic [14:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] wd);
        bit ok = 1'b0;
        addr = a; we = w; be = b; wdata = wd; req[d] = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (gnt[d]) ok = 1'b1;
            @(posedge clk); #1;
        end
        req[d] = 1'b0;
        if (!ok) check_vec("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_resp(input int d, input int n, output logic [31:0] rd);
        for (int i = 0; i < 20 && r_n[d] <= n; i++) begin
            @(posedge clk); #1;
        end
        if (r_n[d] <= n) begin
            check_vec("resp_timeout", 32'd0, 32'd1);
            rd = 'x;
        end else begin
            rd = r_dat[d][n];
            check_vec("latency", 32'(r_cyc[d][n] - g_cyc[d][n]), 32'(LAT));
        end
    endtask

    task automatic txn(input int d, input logic [14:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] wd, output logic [31:0] rd);
        int n = g_n[d];
        issue(d, a, w, b, wd);
        wait_resp(d, n, rd);
    endtask

    logic [31:0] rd;
    int          n;
    logic        gg [4];
    logic        ss [4];
    localparam logic [3:0] WAKE_GNT = 4'b1000;
    localparam logic [3:0] WAKE_SLP = 4'b0001;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_vec("rst_gnt", 32'(gnt), 32'd0);
        check_vec("rst_rvalid", 32'(rvalid), 32'd0);
        check_vec("rst_rdata", rdata[2], 32'd0);
        check_vec("rst_sleep", 32'(slp[2]), 32'd0);
        @(posedge clk); #1;
        rstn_i = 1'b1;

        // contiguous mapping
        txn(0, 15'h2000, 1'b1, 4'hF, 32'hDEADBEEF, rd);
        check_vec("c_wr_rdata0", rd, 32'd0);
        txn(0, 15'h0000, 1'b1, 4'hF, 32'h12345678, rd);
        txn(0, 15'h2000, 1'b0, 4'hF, 32'd0, rd);
        check_vec("c_rd_2000", rd, 32'hDEADBEEF);
        txn(0, 15'h0000, 1'b0, 4'hF, 32'd0, rd);
        check_vec("c_rd_0000", rd, 32'h12345678);

        // byte enables
        txn(0, 15'h0000, 1'b1, 4'hF, 32'h00000000, rd);
        txn(0, 15'h0000, 1'b1, 4'b0101, 32'hAABBCCDD, rd);
        txn(0, 15'h0000, 1'b0, 4'hF, 32'd0, rd);
        check_vec("be_0101", rd, 32'h00BB00DD);

        // interleaved: back-to-back writes then a read burst
        n = g_n[1];
        issue(1, 15'h0000, 1'b1, 4'hF, 32'h11111111);
        issue(1, 15'h0004, 1'b1, 4'hF, 32'h22222222);
        issue(1, 15'h0008, 1'b1, 4'hF, 32'h33333333);
        wait_resp(1, n + 2, rd);
        n = g_n[1];
        issue(1, 15'h0000, 1'b0, 4'hF, 32'd0);
        issue(1, 15'h0004, 1'b0, 4'hF, 32'd0);
        issue(1, 15'h0008, 1'b0, 4'hF, 32'd0);
        wait_resp(1, n + 2, rd);
        check_vec("ilv_gnt_b2b", 32'(g_cyc[1][n+2] - g_cyc[1][n]), 32'd2);
        check_vec("ilv_lat0", 32'(r_cyc[1][n] - g_cyc[1][n]), 32'(LAT));
        check_vec("ilv_lat1", 32'(r_cyc[1][n+1] - g_cyc[1][n+1]), 32'(LAT));
        check_vec("ilv_rd0", r_dat[1][n], 32'h11111111);
        check_vec("ilv_rd1", r_dat[1][n+1], 32'h22222222);
        check_vec("ilv_rd2", r_dat[1][n+2], 32'h33333333);
        check_vec("ilv_rsp_b2b", 32'(r_cyc[1][n+2] - r_cyc[1][n]), 32'd2);

        // sleep/wake: d2 has been idle since reset
        check_vec("all_asleep", 32'(slp[2]), 32'hF);
        txn(2, 15'h4000, 1'b1, 4'hF, 32'hCAFEF00D, rd);
        check_vec("bank2_woken", 32'(slp[2]), 32'b1011);
        n = g_n[2];
        issue(2, 15'h4000, 1'b0, 4'hF, 32'd0);
        repeat (7) @(posedge clk);
        #1;
        check_vec("idle7_awake", 32'(slp[2][2]), 32'd0);
        @(posedge clk); #1;
        check_vec("idle8_sleep", 32'(slp[2][2]), 32'd1);
        wait_resp(2, n, rd);
        check_vec("sleep_rd", rd, 32'hCAFEF00D);

        n = g_n[2];
        addr = 15'h4000; we = 1'b0; be = 4'hF; req[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            gg[k] = gnt[2];
            ss[k] = slp[2][2];
            if (k < 3) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        req[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_vec($sformatf("wake_gnt%0d", k), 32'(gg[k]), 32'(WAKE_GNT[k]));
            check_vec($sformatf("wake_slp%0d", k), 32'(ss[k]), 32'(WAKE_SLP[k]));
        end
        wait_resp(2, n, rd);
        check_vec("wake_data", rd, 32'hCAFEF00D);

        // reset while bank2 is waking, right behind a grant to bank0
        repeat (9) @(posedge clk);
        #1;
        txn(2, 15'h0000, 1'b0, 4'hF, 32'd0, rd);
        check_vec("pre_b2_asleep", 32'(slp[2][2]), 32'd1);
        issue(2, 15'h0000, 1'b0, 4'hF, 32'd0);
        addr = 15'h4000; we = 1'b0; req[2] = 1'b1;
        @(posedge clk); #1;
        check_vec("pre_rst_pending", 32'(rvalid[2]), 32'(LAT == 2));
        rstn_i = 1'b0;
        req[2] = 1'b0;
        #1;
        check_vec("rst_wake_rvalid", 32'(rvalid[2]), 32'd0);
        check_vec("rst_wake_rdata", rdata[2], 32'd0);
        check_vec("rst_wake_sleep", 32'(slp[2]), 32'd0);
        @(posedge clk); #1;
        rstn_i = 1'b1;
        addr = 15'h4000; req[2] = 1'b1;
        @(negedge clk);
        check_vec("post_rst_gnt", 32'(gnt[2]), 32'd1);
        check_vec("post_rst_rvalid", 32'(rvalid[2]), 32'd0);
        @(posedge clk); #1;
        req[2] = 1'b0;
        wait_resp(2, 0, rd);

        check_vec("idle0_nosleep", 32'(slp[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
